// File: rtl/karatsuba_mul_16_pkg.sv
// Shared widths and operand/product types for the 16-bit Karatsuba multiplier.
// Pipelined variant selected in the top with KARATSUBA_PIPE_EN.
package karatsuba_pkg;

    localparam int N    = 16;
    localparam int HALF = N / 2;
    localparam int PW   = 2 * N;

    typedef logic [N-1:0]    operand_t;
    typedef logic [PW-1:0]   product_t;
    typedef logic [HALF-1:0] half_t;

endpackage : karatsuba_pkg

// File: rtl/karatsuba_mul_8.sv
// Combinational unsigned 8x8 -> 16 multiplier, Karatsuba on 4-bit halves.
// The 5-bit middle sums are resolved with the carry identity so only 4x4 products remain.
module karatsuba_mul_8
    import karatsuba_pkg::*;
(
    input  logic [HALF-1:0] a,
    input  logic [HALF-1:0] b,
    output logic [N-1:0]    p
);

    localparam int Q = HALF / 2;

    logic [Q-1:0]      ah_s;
    logic [Q-1:0]      al_s;
    logic [Q-1:0]      bh_s;
    logic [Q-1:0]      bl_s;
    logic [HALF-1:0]   p_hi_s;
    logic [HALF-1:0]   p_lo_s;
    logic [HALF-1:0]   p_mid_s;
    logic [Q:0]        sa_s;
    logic [Q:0]        sb_s;
    logic [Q:0]        cross_s;
    logic [HALF+1:0]   zm_s;
    logic [HALF+1:0]   z1_s;

    assign ah_s = a[HALF-1:Q];
    assign al_s = a[Q-1:0];
    assign bh_s = b[HALF-1:Q];
    assign bl_s = b[Q-1:0];

    assign sa_s = {1'b0, ah_s} + {1'b0, al_s};
    assign sb_s = {1'b0, bh_s} + {1'b0, bl_s};

    // Three plain 4x4 products, zero-extended so the result never wraps.
    assign p_hi_s  = {{Q{1'b0}}, ah_s} * {{Q{1'b0}}, bh_s};
    assign p_lo_s  = {{Q{1'b0}}, al_s} * {{Q{1'b0}}, bl_s};
    assign p_mid_s = {{Q{1'b0}}, sa_s[Q-1:0]} * {{Q{1'b0}}, sb_s[Q-1:0]};

    assign cross_s = (sa_s[Q] ? {1'b0, sb_s[Q-1:0]} : 5'd0)
                   + (sb_s[Q] ? {1'b0, sa_s[Q-1:0]} : 5'd0);

    // (sa*sb) peaks at 900, so a 10-bit middle product is wide enough.
    assign zm_s = {2'b00, p_mid_s}
                + {1'b0, cross_s, 4'd0}
                + {1'b0, (sa_s[Q] & sb_s[Q]), 8'd0};

    assign z1_s = zm_s - {2'b00, p_hi_s} - {2'b00, p_lo_s};

    assign p = {p_hi_s, 8'd0}
             + {2'b00, z1_s, 4'd0}
             + {8'd0, p_lo_s};

endmodule : karatsuba_mul_8

// File: rtl/karatsuba_mul_16.sv
// Registered unsigned 16x16 -> 32 Karatsuba multiplier, latency 1.
// Define KARATSUBA_PIPE_EN to register z0/z2/zm as well (latency 2, full throughput).
module karatsuba_mul_16
    import karatsuba_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  X,
    input  logic [N-1:0]  Y,
    output logic [PW-1:0] Z
);

    logic [HALF-1:0]   xh_s;
    logic [HALF-1:0]   xl_s;
    logic [HALF-1:0]   yh_s;
    logic [HALF-1:0]   yl_s;
    logic [HALF:0]     sx_s;
    logic [HALF:0]     sy_s;
    logic [HALF:0]     cross_s;
    logic [N-1:0]      z2_s;
    logic [N-1:0]      z0_s;
    logic [N-1:0]      pm_s;
    logic [N+1:0]      zm_s;
    logic [N-1:0]      z2_q_s;
    logic [N-1:0]      z0_q_s;
    logic [N+1:0]      zm_q_s;
    logic [N+1:0]      z1_s;
    logic [PW-1:0]     z_next_s;

    assign xh_s = X[N-1:HALF];
    assign xl_s = X[HALF-1:0];
    assign yh_s = Y[N-1:HALF];
    assign yl_s = Y[HALF-1:0];

    assign sx_s = {1'b0, xh_s} + {1'b0, xl_s};
    assign sy_s = {1'b0, yh_s} + {1'b0, yl_s};

    karatsuba_mul_8 u_mul_hi (
        .a (xh_s),
        .b (yh_s),
        .p (z2_s)
    );

    karatsuba_mul_8 u_mul_lo (
        .a (xl_s),
        .b (yl_s),
        .p (z0_s)
    );

    karatsuba_mul_8 u_mul_mid (
        .a (sx_s[HALF-1:0]),
        .b (sy_s[HALF-1:0]),
        .p (pm_s)
    );

    // Carry bits of the 9-bit sums add shifted copies of the other low byte.
    assign cross_s = (sx_s[HALF] ? {1'b0, sy_s[HALF-1:0]} : 9'd0)
                   + (sy_s[HALF] ? {1'b0, sx_s[HALF-1:0]} : 9'd0);

    assign zm_s = {2'b00, pm_s}
                + {1'b0, cross_s, 8'd0}
                + {1'b0, (sx_s[HALF] & sy_s[HALF]), 16'd0};

`ifdef KARATSUBA_PIPE_EN
    logic [N-1:0] z2_r;
    logic [N-1:0] z0_r;
    logic [N+1:0] zm_r;

    // Partial-product stage between the multipliers and the combine adders.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z2_r <= 16'd0;
            z0_r <= 16'd0;
            zm_r <= 18'd0;
        end else begin
            z2_r <= z2_s;
            z0_r <= z0_s;
            zm_r <= zm_s;
        end
    end

    assign z2_q_s = z2_r;
    assign z0_q_s = z0_r;
    assign zm_q_s = zm_r;
`else
    assign z2_q_s = z2_s;
    assign z0_q_s = z0_s;
    assign zm_q_s = zm_s;
`endif

    // z1 = Xh*Yl + Xl*Yh, never negative and at most 17 bits wide.
    assign z1_s = zm_q_s - {2'b00, z2_q_s} - {2'b00, z0_q_s};

    assign z_next_s = {z2_q_s, 16'd0}
                    + {6'd0, z1_s, 8'd0}
                    + {16'd0, z0_q_s};

    // Output product register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Z <= 32'd0;
        end else begin
            Z <= z_next_s;
        end
    end

endmodule : karatsuba_mul_16

// File: tb/tb_karatsuba_mul_16.sv
// Self-checking bench for karatsuba_mul_16 against a plain X*Y reference with latency queue.
module tb_karatsuba_mul_16;

`ifdef KARATSUBA_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] X;
    logic [15:0] Y;
    logic [31:0] Z;

    int unsigned vectors;
    int unsigned miscompares;
    logic [31:0] exp_q[$];

    karatsuba_mul_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .X     (X),
        .Y     (Y),
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic [63:0] wide;
        wide = 64'(a) * 64'(b);
        return wide[31:0];
    endfunction

    // Pipeline contents right after reset release: stages hold zero.
    task automatic seed_queue();
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back(32'd0);
    endtask

    // Drive one pair before a posedge, then check Z at the following negedge.
    task automatic step(input logic [15:0] a, input logic [15:0] b, input string name);
        X = a;
        Y = b;
        @(posedge clk);
        exp_q.push_back(ref_mul(a, b));
        while (exp_q.size() > LAT) void'(exp_q.pop_front());
        @(negedge clk);
        vectors++;
        if (exp_q.size() == LAT) begin
            if (Z !== exp_q[0]) begin
                miscompares++;
                $display("FAIL %s: X=%h Y=%h Z=%h expected %h", name, a, b, Z, exp_q[0]);
            end
        end else begin
            miscompares++;
            $display("FAIL %s: reference queue depth %0d expected %0d", name, exp_q.size(), LAT);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        X = 16'hFFFF;
        Y = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (Z !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_hold: Z=%h expected 00000000", Z);
            end
        end
        rst_n = 1'b1;
        seed_queue();
        for (int i = 0; i < LAT; i++) step(16'hFFFF, 16'hFFFF, "reset_release");
    endtask

    task automatic test_directed();
        step(16'd3,     16'd5,     "small");
        step(16'h0000,  16'hBEEF,  "zero_x");
        step(16'h8000,  16'h0002,  "msb_shift");
        step(16'h1234,  16'h5678,  "mixed");
        step(16'h00FF,  16'h0100,  "mid_carry");
        step(16'hFF00,  16'hFF00,  "both_carry");
        step(16'h0101,  16'hFFFF,  "sum_carry");
        step(16'hFFFF,  16'h0000,  "zero_y");
        step(16'h0001,  16'hFFFF,  "identity");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 32; i++) begin
            step(16'(i * 2053 + 7), 16'(16'hFFFF - i * 997), "back_to_back");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 65536; i++) begin
            step(16'($urandom), 16'($urandom), "random");
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) step(16'($urandom), 16'($urandom), "pre_async");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (Z !== 32'd0) begin
            miscompares++;
            $display("FAIL async_reset: Z=%h expected 00000000 without clock edge", Z);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seed_queue();
        for (int i = 0; i < 8; i++) step(16'($urandom), 16'($urandom), "post_async");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        X           = 16'd0;
        Y           = 16'd0;
        rst_n       = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_karatsuba_mul_16
